// File: rtl/latch_loader_pkg.sv
// latch_loader_pkg: shared types and sizing helpers for the latch_loader block.
//   state_t       - FSM state encoding (IDLE, SHIFT, PARITY, LOAD, ERR)
//   cnt_width()   - bit-counter width for a given data width
//   DEFAULT_*     - default data width and its matching counter width
package latch_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    PARITY,
    LOAD,
    ERR
  } state_t;

  // Sized to hold 0..WIDTH. In SHIFT the counter only ever reaches WIDTH-1.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/latch_loader_shift_reg_sipo.sv
// shift_reg_sipo: WIDTH-bit serial-in / parallel-out register with indexed write.
//   clk    - rising-edge clock
//   rst_n  - synchronous active-low reset, clears q
//   clr    - synchronous clear of q
//   we     - write enable: q[idx] <= d
//   idx    - bit position to write
//   d      - serial bit
//   q      - parallel contents
module shift_reg_sipo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic             d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      q <= '0;
    end else if (we) begin
      // Compare against each position rather than indexing directly, so an
      // index register wider than log2(WIDTH) never selects out of range.
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (idx == IDX_W'(i)) q[i] <= d;
      end
    end
  end

endmodule

// File: rtl/latch_loader.sv
// latch_loader: framed serial (LSB first + even parity bit) to parallel loader
// feeding a bank of D-latches.
//   i_clk          - system clock, rising edge
//   i_rst_n        - synchronous active-low reset
//   i_start        - frame start request, honoured only when idle
//   i_sdata        - serial data / parity bit
//   i_sdata_valid  - i_sdata is valid this cycle
//   o_data         - parallel word to the latch D inputs, stable outside loads
//   o_le           - one-cycle latch enable pulse after a good frame
//   o_busy         - high whenever a frame is in progress
//   o_err          - one-cycle pulse on a parity mismatch
module latch_loader
  import latch_loader_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_sdata,
  input  logic             i_sdata_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_le,
  output logic             o_busy,
  output logic             o_err
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   sreg;
  logic               last_bit;
  logic               par_ok;
  logic               sr_clr;
  logic               sr_we;
  logic               load_go;

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  // Even parity: data bits together with the parity bit must XOR to zero.
  assign par_ok   = ~((^sreg) ^ i_sdata);

  shift_reg_sipo #(
    .WIDTH (WIDTH),
    .IDX_W (CNT_W)
  ) u_sreg (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .clr   (sr_clr),
    .we    (sr_we),
    .idx   (cnt),
    .d     (i_sdata),
    .q     (sreg)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sr_clr    = 1'b0;
    sr_we     = 1'b0;
    load_go   = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          sr_clr    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (i_sdata_valid) begin
          sr_we = 1'b1;
          if (last_bit) state_nxt = PARITY;
        end
      end
      PARITY: begin
        if (i_sdata_valid) begin
          if (par_ok) begin
            load_go   = 1'b1;
            state_nxt = LOAD;
          end else begin
            state_nxt = ERR;
          end
        end
      end
      LOAD:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || sr_clr) begin
      cnt <= '0;
    end else if (sr_we) begin
      cnt <= last_bit ? '0 : cnt + CNT_W'(1);
    end
  end

  // The word is captured on the edge entering LOAD so it is already stable
  // while o_le is high and the downstream latches are transparent.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)     o_data <= '0;
    else if (load_go) o_data <= sreg;
  end

  assign o_le   = (state == LOAD);
  assign o_err  = (state == ERR);
  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_latch_loader.sv
// tb_latch_loader: directed self-checking bench for latch_loader (WIDTH=8).
module tb_latch_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       sdata;
  logic       valid;
  logic [7:0] data;
  logic       le;
  logic       busy;
  logic       err;

  int unsigned cyc = 0;
  int unsigned le_n = 0, le_last = 0, le_wide = 0;
  int unsigned err_n = 0, err_last = 0, err_wide = 0;
  logic        le_prev = 1'b0, err_prev = 1'b0;
  int unsigned start_cyc = 0;
  int unsigned tests = 0, fails = 0;

  latch_loader #(.WIDTH(8)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_sdata       (sdata),
    .i_sdata_valid (valid),
    .o_data        (data),
    .o_le          (le),
    .o_busy        (busy),
    .o_err         (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Pulse monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (le === 1'b1) begin
      le_n++;
      le_last = cyc;
      if (le_prev) le_wide++;
    end
    if (err === 1'b1) begin
      err_n++;
      err_last = cyc;
      if (err_prev) err_wide++;
    end
    le_prev  = (le === 1'b1);
    err_prev = (err === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one frame; returns in the LOAD/ERR cycle. Stall bursts of three
  // idle cycles follow bit stall_a / stall_b; i_start is re-asserted along
  // with bit restart_at (-1 disables each option).
  task automatic send_frame(input logic [7:0] d, input logic par,
                            input int stall_a, input int stall_b, input int restart_at);
    logic [7:0] w;
    w = d;
    start     = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      sdata = w[i];
      valid = 1'b1;
      start = (i == restart_at);
      tick();
      start = 1'b0;
      if (i == stall_a || i == stall_b) begin
        for (int k = 0; k < 3; k++) begin
          valid = 1'b0;
          sdata = 1'($urandom);
          tick();
        end
      end
    end
    sdata = par;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    sdata = 1'b0;
  endtask

  initial begin
    int unsigned le0, err0, first_le;

    rst_n = 1'b0;
    start = 1'b0;
    sdata = 1'b0;
    valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start = 1'($urandom);
      sdata = 1'($urandom);
      valid = 1'($urandom);
      tick();
    end
    check("rst_data", {24'd0, data}, 32'h00);
    check("rst_le",   {31'd0, le},   32'd0);
    check("rst_err",  {31'd0, err},  32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    start = 1'b0;
    valid = 1'b0;
    tick();

    // Good frame 8'hA5, even parity bit 0.
    le0 = le_n; err0 = err_n;
    send_frame(8'hA5, 1'b0, -1, -1, -1);
    check("a5_le_now", {31'd0, le}, 32'd1);
    tick();
    check("a5_le_count",   le_n - le0, 32'd1);
    check("a5_le_latency", le_last - start_cyc, 32'd10);
    check("a5_le_width",   le_wide, 32'd0);
    check("a5_no_err",     err_n - err0, 32'd0);
    check("a5_data",       {24'd0, data}, 32'hA5);
    check("a5_idle_busy",  {31'd0, busy}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      sdata = 1'($urandom);
      valid = 1'($urandom);
      tick();
    end
    valid = 1'b0;
    check("a5_data_hold",  {24'd0, data}, 32'hA5);
    check("a5_idle_le",    le_n - le0, 32'd1);

    // Parity error: 8'h01 needs parity 1, send 0.
    le0 = le_n; err0 = err_n;
    send_frame(8'h01, 1'b0, -1, -1, -1);
    tick();
    check("perr_err_count",   err_n - err0, 32'd1);
    check("perr_err_latency", err_last - start_cyc, 32'd10);
    check("perr_err_width",   err_wide, 32'd0);
    check("perr_no_le",       le_n - le0, 32'd0);
    check("perr_data_kept",   {24'd0, data}, 32'hA5);

    // Stalled frame 8'h3C, parity 0, 3-cycle stalls after bits 2 and 7.
    le0 = le_n;
    send_frame(8'h3C, 1'b0, 2, 7, -1);
    tick();
    check("stall_le_count",   le_n - le0, 32'd1);
    check("stall_le_latency", le_last - start_cyc, 32'd16);
    check("stall_data",       {24'd0, data}, 32'h3C);

    // Reset after four data bits of a partial frame.
    le0 = le_n; err0 = err_n;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sdata = 1'b1;
      valid = 1'b1;
      tick();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_data", {24'd0, data}, 32'h00);
    for (int i = 0; i < 8; i++) tick();
    valid = 1'b0;
    check("midrst_no_le",  le_n - le0, 32'd0);
    check("midrst_no_err", err_n - err0, 32'd0);

    // i_start repeated during SHIFT has no effect; 8'h96 has four ones.
    le0 = le_n;
    send_frame(8'h96, 1'b0, -1, -1, 3);
    tick();
    check("restart_le_count",   le_n - le0, 32'd1);
    check("restart_le_latency", le_last - start_cyc, 32'd10);
    check("restart_data",       {24'd0, data}, 32'h96);

    // Back-to-back: 8'hFF parity 0, then 8'h80 parity 1 started in the IDLE
    // cycle right after LOAD.
    le0 = le_n;
    send_frame(8'hFF, 1'b0, -1, -1, -1);
    check("b2b_first_data", {24'd0, data}, 32'hFF);
    tick();
    first_le = le_last;
    send_frame(8'h80, 1'b1, -1, -1, -1);
    tick();
    check("b2b_le_count",   le_n - le0, 32'd2);
    check("b2b_le_spacing", le_last - first_le, 32'd11);
    check("b2b_second_data", {24'd0, data}, 32'h80);
    check("b2b_le_width",   le_wide, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/latch_loader.md
# latch_loader

Serial-to-parallel loader that sits directly upstream of a bank of D-latches. It assembles a framed serial bit stream (LSB first, one even-parity bit) into a WIDTH-bit word. On a good frame it presents the word on a stable bus together with a one-cycle latch-enable pulse, which drives the latches' clock/enable input. On a parity failure it flags an error and leaves the bus untouched.

## Interface
- WIDTH, 8: data bits per frame; ≥1.
- i_clk  input  1  system clock; all state changes on rising edge.
- i_rst_n  input  1  reset, synchronous, active-low.
- i_start  input  1  frame start request; honoured only in IDLE.
- i_sdata  input  1  serial data/parity bit.
- i_sdata_valid  input  1  i_sdata is valid this cycle.
- o_data  output  WIDTH  parallel word; feeds the latch bank D inputs.
- o_le  output  1  latch enable, one-cycle pulse; feeds the latch bank enable.
- o_busy  output  1  high in every state except IDLE.
- o_err  output  1  one-cycle pulse on a parity mismatch.

## Operation
- States: IDLE, SHIFT, PARITY, LOAD, ERR.
- IDLE:
  - i_start=1 -> SHIFT; bit counter cleared to 0; shift register cleared.
  - i_start is ignored in every other state (no queueing).
- SHIFT:
  - Each cycle with i_sdata_valid=1 writes i_sdata into shift-register bit [cnt], then cnt+1.
  - Cycles with valid=0 are stalls; no change.
  - When the WIDTH-th bit is accepted (cnt = WIDTH-1 with valid) -> PARITY.
- PARITY:
  - Waits for valid=1.
  - Bit accepted: even parity holds (XOR of WIDTH data bits and the parity bit = 0) -> LOAD; otherwise -> ERR.
- LOAD:
  - o_data <= shift register; o_le=1 for this single cycle; then -> IDLE.
- ERR:
  - o_err=1 for this single cycle; o_data and o_le unchanged (o_le=0); then -> IDLE.
- Counter width: $clog2(WIDTH+1); never exceeds WIDTH-1 in SHIFT.
- o_data changes only on the edge entering LOAD. It holds its value through the o_le pulse and afterwards, so downstream latches see stable D while transparent.
- i_sdata/i_sdata_valid are ignored in IDLE, LOAD and ERR.
- Reset (i_rst_n=0 at a clock edge), including mid-frame: state IDLE, counter 0, shift register 0, o_data=0, o_le=0, o_err=0, o_busy=0. A partial frame is discarded and no pulse is issued.
- WIDTH=1: SHIFT accepts exactly one bit and then enters PARITY.

## Timing
- All outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.
- o_busy goes high the cycle after i_start is sampled in IDLE.
- o_le (or o_err) is high in the cycle after the parity bit is accepted.
- Back-to-back frames: IDLE is entered the cycle after LOAD/ERR. i_start is sampled there, giving a minimum of WIDTH+3 cycles per frame with continuous valid.
- Minimum frame latency: i_start edge to o_le high = WIDTH+2 cycles with valid held high.
- Reset dominates every other input in the same cycle.

## Structure
- Package latch_loader_pkg:
  - state enum type (IDLE, SHIFT, PARITY, LOAD, ERR);
  - localparam for counter width as a function of WIDTH.
- One sub-module: shift_reg_sipo, a WIDTH-bit indexed-write serial-in/parallel-out register with clear and write-enable. The FSM, counter and output registers stay in latch_loader.
- Top-level integration: o_data -> latch bank D inputs, o_le -> latch bank clock/enable.

## Test plan
- Reset: hold i_rst_n=0 for 2 cycles with random inputs -> o_data=8'h00, o_le=0, o_err=0, o_busy=0.
- Good frame, WIDTH=8: i_start, then bits of 8'hA5 LSB first (1,0,1,0,0,1,0,1), then parity 0, valid continuous -> o_le=1 for exactly one cycle, 10 cycles after i_start; o_data=8'hA5 and held thereafter.
- Parity error: frame 8'h01 with parity bit 0 -> o_err one-cycle pulse; o_le stays 0; o_data keeps its previous value 8'hA5.
- Stalls: frame 8'h3C, parity 0, with valid deasserted for 3 cycles after bits 2 and 7 -> o_data=8'h3C, o_le pulse 6 cycles later than the unstalled case.
- Reset mid-frame and ignored start: i_rst_n=0 after 4 data bits -> IDLE, no o_le/o_err pulse. Then i_start pulsed again during SHIFT of a new frame -> no effect, frame completes normally.
- Back-to-back: frames 8'hFF (parity 0) and 8'h80 (parity 1), i_start asserted in the IDLE cycle right after LOAD -> two o_le pulses 11 cycles apart; o_data=8'hFF, then 8'h80.
